alu_mb_seq: RTL and testbench

Multi-byte ALU sequencer. It accepts one wide operation on two `8*NBYTES`-bit operands and runs it through a single internal `alu8` instance, one byte per clock. Between bytes it chains carry/borrow (and shift bits). It is the controller that lets the 8-bit ALU datapath serve 16/32/64-bit instructions without widening the datapath.

---
 rtl/alu_mb_seq.sv | 196 +++++++++++++++++++
 tb/tb_alu_mb_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mb_seq.sv
// Multi-byte ALU sequencer: streams a wide op through one alu8, a byte per clock.
// Optional Zero/Neg flag registers are built when ALU_MB_SEQ_FLAGS_EN is defined.
module alu8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic [2:0] i_op,
  input  logic       i_cin,
  output logic [7:0] o_y,
  output logic       o_cout
);
  logic [8:0] w_sum;
  logic [8:0] w_dif;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {8'b0, i_cin};
  // Bit 8 of the 9-bit difference is the borrow out
  assign w_dif = {1'b0, i_a} - {1'b0, i_b} - {8'b0, i_cin};

  always_comb begin
    o_y    = 8'h00;
    o_cout = 1'b0;
    unique case (i_op)
      3'b000: begin o_y = w_sum[7:0]; o_cout = w_sum[8]; end
      3'b001: begin o_y = w_dif[7:0]; o_cout = w_dif[8]; end
      3'b010: o_y = i_a & i_b;
      3'b011: o_y = i_a | i_b;
      3'b100: o_y = i_a ^ i_b;
      3'b101: begin o_y = {i_a[6:0], 1'b0}; o_cout = i_a[7]; end
      3'b110: begin o_y = {1'b0, i_a[7:1]}; o_cout = i_a[0]; end
      3'b111: o_y = ~i_a;
      default: ;
    endcase
  end
endmodule

module alu_mb_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [2:0]            Op,
  input  logic                  Cin,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  output logic                  Busy,
  output logic                  Done,
  output logic [8*NBYTES-1:0]   Y,
  output logic                  Cout,
  output logic                  Zero,
  output logic                  Neg
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2:0]     r_op;
  logic [IW-1:0]  r_idx;
  logic           r_chain;
  logic [W-1:0]   r_y;
  logic           r_cout;
  logic           r_done;

  logic           w_accept;
  logic           w_last;
  logic [IW-1:0]  w_sel;
  logic [IW+2:0]  w_base;
  logic [7:0]     w_a8;
  logic [7:0]     w_b8;
  logic           w_cin;
  logic [7:0]     w_y8;
  logic           w_cout8;
  logic [7:0]     w_byte;
  logic           w_chain_nx;
  logic [W-1:0]   w_ynext;

  assign w_accept = (r_state == S_IDLE) && Start;
  assign w_last   = (r_state == S_RUN) && (r_idx == LAST);

  // shr walks bytes from the top so each byte can take the bit above it
  assign w_sel  = (r_op == OP_SHR) ? (LAST - r_idx) : r_idx;
  assign w_base = {w_sel, 3'b000};
  assign w_a8   = r_a[w_base +: 8];
  assign w_b8   = r_b[w_base +: 8];
  assign w_cin  = ((r_op == OP_ADD) || (r_op == OP_SUB)) ? r_chain : 1'b0;

  alu8 u_alu8 (
    .i_a    (w_a8),
    .i_b    (w_b8),
    .i_op   (r_op),
    .i_cin  (w_cin),
    .o_y    (w_y8),
    .o_cout (w_cout8)
  );

  always_comb begin
    w_byte     = w_y8;
    w_chain_nx = w_cout8;
    unique case (1'b1)
      (r_op == OP_SHL): begin
        w_byte     = {w_y8[7:1], r_chain};
        w_chain_nx = w_a8[7];
      end
      (r_op == OP_SHR): begin
        w_byte     = {r_chain, w_y8[6:0]};
        w_chain_nx = w_a8[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_ynext                = r_y;
    w_ynext[w_base +: 8]   = w_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (Start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 3'b000;
      r_idx   <= '0;
      r_chain <= 1'b0;
      r_y     <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= A;
        r_b     <= B;
        r_op    <= Op;
        r_idx   <= '0;
        r_chain <= ((Op == OP_ADD) || (Op == OP_SUB)) ? Cin : 1'b0;
      end else if (r_state == S_RUN) begin
        r_y     <= w_ynext;
        r_chain <= w_chain_nx;
        r_idx   <= r_idx + 1'b1;
        if (w_last) begin
          r_done <= 1'b1;
          r_cout <= w_cout8;
        end
      end
    end
  end

`ifdef ALU_MB_SEQ_FLAGS_EN
  logic r_zero;
  logic r_neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_last) begin
      r_zero <= (w_ynext == '0);
      r_neg  <= w_ynext[W-1];
    end
  end

  assign Zero = r_zero;
  assign Neg  = r_neg;
`else
  assign Zero = 1'b0;
  assign Neg  = 1'b0;
`endif

  assign Busy = (r_state == S_RUN);
  assign Done = r_done;
  assign Y    = r_y;
  assign Cout = r_cout;
endmodule

// File: tb/tb_alu_mb_seq.sv
// Scoreboard bench for alu_mb_seq: random and directed wide ops vs a 32-bit model.
// Flag expectations follow whether ALU_MB_SEQ_FLAGS_EN is defined.
module tb_alu_mb_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         Start;
  logic [2:0]   Op;
  logic         Cin;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Y;
  logic         Cout;
  logic         Zero;
  logic         Neg;

  alu_mb_seq #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .Op    (Op),
    .Cin   (Cin),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .Y     (Y),
    .Cout  (Cout),
    .Zero  (Zero),
    .Neg   (Neg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         z;
    logic         n;
    int           at;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic ci,
                                 input int at);
    exp_t e;
    logic [W:0] s;
    e.c = 1'b0;
    case (op)
      3'd0: begin
        s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        e.y = s[W-1:0];
        e.c = s[W];
      end
      3'd1: begin
        e.y = a - b - {{(W-1){1'b0}}, ci};
        e.c = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, ci}));
      end
      3'd2: e.y = a & b;
      3'd3: e.y = a | b;
      3'd4: e.y = a ^ b;
      3'd5: begin e.y = a << 1; e.c = a[W-1]; end
      3'd6: begin e.y = a >> 1; e.c = a[0]; end
      default: e.y = ~a;
    endcase
`ifdef ALU_MB_SEQ_FLAGS_EN
    e.z = (e.y == '0);
    e.n = e.y[W-1];
`else
    e.z = 1'b0;
    e.n = 1'b0;
`endif
    e.at = at;
    return e;
  endfunction

  // Monitor: every Done pops one expectation
  always @(negedge clk) begin
    if (!rst && Done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got Done=1 expected no Done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", W'(cyc), W'(e.at));
        chk("y", Y, e.y);
        chk("cout", W'(Cout), W'(e.c));
        chk("zero", W'(Zero), W'(e.z));
        chk("neg", W'(Neg), W'(e.n));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (Busy) chk("idle_timeout", W'(Busy), '0);
  endtask

  // Issue one op, then toss garbage on the inputs (and Start) while busy
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ci);
    int n = 0;
    @(negedge clk);
    wait_idle();
    Start = 1'b1; Op = op; A = a; B = b; Cin = ci;
    q.push_back(model(op, a, b, ci, cyc + 1 + NB));
    @(negedge clk);
    chk("busy_after_accept", W'(Busy), W'(1));
    while (Busy && n < 20) begin
      Start = 1'($urandom_range(0, 1));
      A = $urandom; B = $urandom; Op = 3'($urandom); Cin = 1'($urandom);
      @(negedge clk);
      n++;
    end
    Start = 1'b0;
    if (n >= 20) chk("done_timeout", W'(Busy), '0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; Start = 1'b0; Op = '0; Cin = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(Busy), '0);
    chk("rst_done", W'(Done), '0);
    chk("rst_y", Y, '0);
    chk("rst_cout", W'(Cout), '0);
    chk("rst_zero", W'(Zero), '0);
    chk("rst_neg", W'(Neg), '0);
    rst = 1'b0;

    issue(3'd0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0);
    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    issue(3'd1, 32'h0000_0000, 32'h0000_0001, 1'b0);
    issue(3'd5, 32'h8000_0001, 32'hDEAD_BEEF, 1'b1);
    issue(3'd6, 32'h0000_0101, 32'h1234_5678, 1'b1);
    issue(3'd0, 32'h1234_5678, 32'h0FED_CBA8, 1'b1);
    issue(3'd1, 32'h0000_0005, 32'h0000_0004, 1'b1);
    issue(3'd7, 32'h0F0F_00FF, 32'h0, 1'b1);

    // Start held high: accepts only every NB+1 edges
    @(negedge clk);
    wait_idle();
    Start = 1'b1; Op = 3'd4; A = 32'hF0F0_F0F0; B = 32'hFFFF_0000; Cin = 1'b0;
    for (int i = 0; i < 2 * (NB + 1); i++) begin
      if (i % (NB + 1) == 0)
        q.push_back(model(3'd4, A, B, 1'b0, cyc + 1 + NB));
      @(negedge clk);
      chk("b2b_busy", W'(Busy), W'((i % (NB + 1)) != NB));
    end
    Start = 1'b0;
    @(negedge clk);
    chk("b2b_stop", W'(Busy), '0);

    // Reset two edges into an add aborts it
    Start = 1'b1; Op = 3'd0; A = 32'h1122_3344; B = 32'h0101_0101; Cin = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", W'(Busy), '0);
    chk("abort_done", W'(Done), '0);
    chk("abort_y", Y, '0);
    chk("abort_cout", W'(Cout), '0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(3'd0, 32'd5, 32'd7, 1'b0);

    for (int i = 0; i < 60; i++)
      issue(3'($urandom), pick(), pick(), 1'($urandom));

    begin
      int n = 0;
      while (q.size() != 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("queue_drained", W'(q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
